// File: rtl/mdpath_p.sv
`default_nettype none
// ============================================================================
//  Module      : mdpath_p
//  Description : Multi-cycle MIPS-style datapath. Holds PC, IR, MDR, A, B,
//                ALUOut and an NREG x 32 register file. The control unit
//                drives every strobe and select from outside. MIO_ready acts
//                as a global enable that freezes all state while low.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdpath_p #(
    parameter int          NREG     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          LINK_REG = 31
) (
    input  logic        clk,
    input  logic        reset,          // asynchronous, active low
    input  logic        MIO_ready,
    input  logic        IorD,
    input  logic        IRWrite,
    input  logic        RegWrite,
    input  logic        ALUSrcA,
    input  logic        PCWrite,
    input  logic        PCWriteCond,
    input  logic        Branch,
    input  logic        ExtSel,
    input  logic [1:0]  RegDst,
    input  logic [1:0]  MemtoReg,
    input  logic [1:0]  ALUSrcB,
    input  logic [1:0]  PCSource,
    input  logic [2:0]  ALU_operation,
    input  logic [31:0] data2CPU,
    output logic [31:0] PC_Current,
    output logic [31:0] Inst,
    output logic [31:0] data_out,
    output logic [31:0] M_addr,
    output logic        zero,
    output logic        overflow
);

    // Register-file address width; NREG is restricted to powers of two.
    localparam int              c_aw   = $clog2(NREG);
    localparam logic [c_aw-1:0] c_link = LINK_REG[c_aw-1:0];

    // Architectural state
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_mdr;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_aluout;
    logic [31:0] r_rf [NREG];

    // Combinational datapath
    logic            w_en;
    logic [c_aw-1:0] w_ra;
    logic [c_aw-1:0] w_rb;
    logic [c_aw-1:0] w_wa;
    logic [31:0]     w_rd_a;
    logic [31:0]     w_rd_b;
    logic [31:0]     w_wd;
    logic [31:0]     w_imm;
    logic [31:0]     w_alu_a;
    logic [31:0]     w_alu_b;
    logic [31:0]     w_sum;
    logic [31:0]     w_diff;
    logic [31:0]     w_alu_res;
    logic            w_ovf;
    logic            w_zero;
    logic            w_pc_ld;
    logic [31:0]     w_pc_next;

    assign w_en = MIO_ready;

    // Read ports index with the low bits of rs/rt; r0 is hardwired to zero.
    assign w_ra   = r_ir[21 +: c_aw];
    assign w_rb   = r_ir[16 +: c_aw];
    assign w_rd_a = (w_ra == '0) ? 32'h0 : r_rf[w_ra];
    assign w_rd_b = (w_rb == '0) ? 32'h0 : r_rf[w_rb];

    // Immediate extension: ExtSel=1 zero-extends (logical ops), else sign-extends.
    assign w_imm = ExtSel ? {16'h0000, r_ir[15:0]} : {{16{r_ir[15]}}, r_ir[15:0]};

    // Destination register select (rt, rd, link register).
    always_comb begin
        w_wa = r_ir[16 +: c_aw];
        case (RegDst)
            2'd0:    w_wa = r_ir[16 +: c_aw];
            2'd1:    w_wa = r_ir[11 +: c_aw];
            2'd2:    w_wa = c_link;
            default: w_wa = r_ir[16 +: c_aw];
        endcase
    end

    // Write-back data select (ALU result, load data, lui, link address).
    always_comb begin
        w_wd = r_aluout;
        case (MemtoReg)
            2'd0:    w_wd = r_aluout;
            2'd1:    w_wd = r_mdr;
            2'd2:    w_wd = {r_ir[15:0], 16'h0000};
            default: w_wd = r_pc;
        endcase
    end

    // ALU operand selection.
    always_comb begin
        w_alu_a = ALUSrcA ? r_a : r_pc;
        w_alu_b = r_b;
        case (ALUSrcB)
            2'd0:    w_alu_b = r_b;
            2'd1:    w_alu_b = 32'd4;
            2'd2:    w_alu_b = w_imm;
            default: w_alu_b = {w_imm[29:0], 2'b00};
        endcase
    end

    assign w_sum  = w_alu_a + w_alu_b;
    assign w_diff = w_alu_a - w_alu_b;

    // ALU function and signed-overflow detection (ADD/SUB only).
    always_comb begin
        w_alu_res = 32'h0;
        w_ovf     = 1'b0;
        case (ALU_operation)
            3'b000: w_alu_res = w_alu_a & w_alu_b;
            3'b001: w_alu_res = w_alu_a | w_alu_b;
            3'b010: begin
                w_alu_res = w_sum;
                w_ovf     = (w_alu_a[31] == w_alu_b[31]) && (w_sum[31] != w_alu_a[31]);
            end
            3'b011: w_alu_res = w_alu_a ^ w_alu_b;
            3'b100: w_alu_res = ~(w_alu_a | w_alu_b);
            3'b101: w_alu_res = w_alu_b >> w_alu_a[4:0];
            3'b110: begin
                w_alu_res = w_diff;
                w_ovf     = (w_alu_a[31] != w_alu_b[31]) && (w_diff[31] != w_alu_a[31]);
            end
            default: w_alu_res = {31'h0, ($signed(w_alu_a) < $signed(w_alu_b))};
        endcase
    end

    assign w_zero = (w_alu_res == 32'h0);

    // Next-PC source and load condition (beq when Branch=1, bne when Branch=0).
    always_comb begin
        w_pc_next = w_alu_res;
        case (PCSource)
            2'd0:    w_pc_next = w_alu_res;
            2'd1:    w_pc_next = r_aluout;
            2'd2:    w_pc_next = {r_pc[31:28], r_ir[25:0], 2'b00};
            default: w_pc_next = r_a;
        endcase
        w_pc_ld = PCWrite || (PCWriteCond && (Branch ? w_zero : !w_zero));
    end

    // Datapath registers; everything holds while the memory is not ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc     <= RESET_PC;
            r_ir     <= 32'h0;
            r_mdr    <= 32'h0;
            r_a      <= 32'h0;
            r_b      <= 32'h0;
            r_aluout <= 32'h0;
        end else if (w_en) begin
            if (w_pc_ld) begin
                r_pc <= w_pc_next;
            end
            if (IRWrite) begin
                r_ir <= data2CPU;
            end
            r_mdr    <= data2CPU;
            r_a      <= w_rd_a;
            r_b      <= w_rd_b;
            r_aluout <= w_alu_res;
        end
    end

    // Register file write port; A/B sample the pre-write contents on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= 32'h0;
            end
        end else if (w_en && RegWrite && (w_wa != '0)) begin
            r_rf[w_wa] <= w_wd;
        end
    end

    assign PC_Current = r_pc;
    assign Inst       = r_ir;
    assign data_out   = r_b;
    assign M_addr     = IorD ? r_aluout : r_pc;
    assign zero       = w_zero;
    assign overflow   = w_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mdpath_p.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdpath_p
//  Description : Scoreboard bench for mdpath_p. Two instances (32- and
//                8-entry register files) share one stimulus stream; a
//                cycle-level reference model predicts their outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdpath_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        MIO_ready, IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch, ExtSel;
    logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
    logic [2:0]  ALU_operation;
    logic [31:0] data2CPU;
    logic [31:0] pc0, inst0, dout0, maddr0, pc1, inst1, dout1, maddr1;
    logic        zero0, ovf0, zero1, ovf1;

    mdpath_p dut (
        .clk(clk), .reset(reset), .MIO_ready(MIO_ready), .IorD(IorD), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .Branch(Branch), .ExtSel(ExtSel), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALU_operation(ALU_operation),
        .data2CPU(data2CPU), .PC_Current(pc0), .Inst(inst0), .data_out(dout0),
        .M_addr(maddr0), .zero(zero0), .overflow(ovf0)
    );

    mdpath_p #(.NREG(8), .RESET_PC(32'h0000_0100), .LINK_REG(7)) dut8 (
        .clk(clk), .reset(reset), .MIO_ready(MIO_ready), .IorD(IorD), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .Branch(Branch), .ExtSel(ExtSel), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALU_operation(ALU_operation),
        .data2CPU(data2CPU), .PC_Current(pc1), .Inst(inst1), .data_out(dout1),
        .M_addr(maddr1), .zero(zero1), .overflow(ovf1)
    );

    typedef struct packed {
        logic        rdy, iord, irw, rw, srca, pcw, pcwc, br, ext;
        logic [1:0]  rdst, m2r, srcb, pcsrc;
        logic [2:0]  op;
        logic [31:0] din;
    } ctl_t;

    typedef struct packed {
        logic [1:0][31:0] pc, inst, dout, maddr;
        logic [1:0]       zero, ovf;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state, index 0 = 32-register instance, 1 = 8-register instance
    logic [31:0] m_pc[2], m_ir[2], m_mdr[2], m_a[2], m_b[2], m_alo[2];
    logic [31:0] m_rf[2][32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k]  = (k == 0) ? 32'h0000_0000 : 32'h0000_0100;
            m_ir[k]  = 32'h0;
            m_mdr[k] = 32'h0;
            m_a[k]   = 32'h0;
            m_b[k]   = 32'h0;
            m_alo[k] = 32'h0;
            for (int r = 0; r < 32; r++) m_rf[k][r] = 32'h0;
        end
    endfunction

    // ALU reference: arithmetic in 64-bit signed, overflow when truncation changes the value
    function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                    output logic [31:0] r, output logic v);
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        v  = 1'b0;
        r  = 32'h0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin s = sa + sb; r = s[31:0]; v = (s != longint'($signed(s[31:0]))); end
            3'd3: r = a ^ b;
            3'd4: r = ~(a | b);
            3'd5: r = b >> a[4:0];
            3'd6: begin s = sa - sb; r = s[31:0]; v = (s != longint'($signed(s[31:0]))); end
            default: r = (sa < sb) ? 32'd1 : 32'd0;
        endcase
    endfunction

    // Drive one cycle of controls, record the predicted outputs, advance the model
    task automatic set_inputs(input ctl_t c);
        exp_t e;
        MIO_ready = c.rdy;  IorD = c.iord;  IRWrite = c.irw;  RegWrite = c.rw;
        ALUSrcA = c.srca;   PCWrite = c.pcw; PCWriteCond = c.pcwc; Branch = c.br;
        ExtSel = c.ext;     RegDst = c.rdst; MemtoReg = c.m2r; ALUSrcB = c.srcb;
        PCSource = c.pcsrc; ALU_operation = c.op; data2CPU = c.din;
        for (int k = 0; k < 2; k++) begin
            logic [31:0] imm, oa, ob, res, npc, wd, ra_v, rb_v;
            logic        v, z, take;
            int          nr, ra, rb, wa;
            nr  = (k == 0) ? 32 : 8;
            imm = c.ext ? {16'h0, m_ir[k][15:0]} : {{16{m_ir[k][15]}}, m_ir[k][15:0]};
            oa  = c.srca ? m_a[k] : m_pc[k];
            case (c.srcb)
                2'd0:    ob = m_b[k];
                2'd1:    ob = 32'd4;
                2'd2:    ob = imm;
                default: ob = imm * 4;
            endcase
            ref_alu(oa, ob, c.op, res, v);
            z = (res == 32'h0);
            e.pc[k]    = m_pc[k];
            e.inst[k]  = m_ir[k];
            e.dout[k]  = m_b[k];
            e.maddr[k] = c.iord ? m_alo[k] : m_pc[k];
            e.zero[k]  = z;
            e.ovf[k]   = v;
            if (c.rdy) begin
                ra   = int'(m_ir[k][25:21]) % nr;
                rb   = int'(m_ir[k][20:16]) % nr;
                ra_v = m_rf[k][ra];
                rb_v = m_rf[k][rb];
                take = c.pcw || (c.pcwc && (c.br ? z : !z));
                case (c.pcsrc)
                    2'd0:    npc = res;
                    2'd1:    npc = m_alo[k];
                    2'd2:    npc = {m_pc[k][31:28], m_ir[k][25:0], 2'b00};
                    default: npc = m_a[k];
                endcase
                if (c.rdst == 2'd1)      wa = int'(m_ir[k][15:11]) % nr;
                else if (c.rdst == 2'd2) wa = (k == 0) ? 31 : 7;
                else                     wa = int'(m_ir[k][20:16]) % nr;
                case (c.m2r)
                    2'd0:    wd = m_alo[k];
                    2'd1:    wd = m_mdr[k];
                    2'd2:    wd = {m_ir[k][15:0], 16'h0};
                    default: wd = m_pc[k];
                endcase
                if (c.rw && wa != 0) m_rf[k][wa] = wd;
                if (take)  m_pc[k] = npc;
                if (c.irw) m_ir[k] = c.din;
                m_mdr[k] = c.din;
                m_a[k]   = ra_v;
                m_b[k]   = rb_v;
                m_alo[k] = res;
            end
        end
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input ctl_t c);
        set_inputs(c);
        step();
    endtask

    function automatic ctl_t idle();
        ctl_t c;
        c = '0;
        c.rdy = 1'b1;
        return c;
    endfunction

    function automatic ctl_t fetch(input logic [31:0] instr);
        ctl_t c;
        c = idle();
        c.irw = 1'b1; c.srcb = 2'd1; c.op = 3'b010; c.pcw = 1'b1; c.din = instr;
        return c;
    endfunction

    function automatic ctl_t rnd_ctl();
        ctl_t c;
        c.rdy  = ($urandom_range(0, 3) != 0);
        c.iord = 1'($urandom_range(0, 1));  c.irw  = 1'($urandom_range(0, 1));
        c.rw   = 1'($urandom_range(0, 1));  c.srca = 1'($urandom_range(0, 1));
        c.pcw  = 1'($urandom_range(0, 1));  c.pcwc = 1'($urandom_range(0, 1));
        c.br   = 1'($urandom_range(0, 1));  c.ext  = 1'($urandom_range(0, 1));
        c.rdst = 2'($urandom_range(0, 3));  c.m2r  = 2'($urandom_range(0, 3));
        c.srcb = 2'($urandom_range(0, 3));  c.pcsrc = 2'($urandom_range(0, 3));
        c.op   = 3'($urandom_range(0, 7));
        c.din  = $urandom;
        return c;
    endfunction

    // fetch, decode, execute (A + sign-extended imm), write rt
    task automatic load_imm_reg(input logic [31:0] instr);
        ctl_t c;
        cyc(fetch(instr));
        cyc(idle());
        c = idle(); c.srca = 1'b1; c.srcb = 2'd2; c.op = 3'b010;
        cyc(c);
        c = idle(); c.rw = 1'b1;
        cyc(c);
    endtask

    // Asynchronous reset between edges (after the monitor sample), released after one edge
    task automatic do_reset();
        #5;
        reset = 1'b0;
        model_reset();
        #1;
        chk("async reset pc0", pc0, 32'h0000_0000);
        chk("async reset pc1", pc1, 32'h0000_0100);
        chk("async reset inst0", inst0, 32'h0);
        chk("async reset dout0", dout0, 32'h0);
        chk("async reset inst1", inst1, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Monitor: compares every presented cycle against the oldest prediction
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("pc[0]",    pc0,    mon_e.pc[0]);
            chk("inst[0]",  inst0,  mon_e.inst[0]);
            chk("dout[0]",  dout0,  mon_e.dout[0]);
            chk("maddr[0]", maddr0, mon_e.maddr[0]);
            chk("zero[0]",  {31'h0, zero0}, {31'h0, mon_e.zero[0]});
            chk("ovf[0]",   {31'h0, ovf0},  {31'h0, mon_e.ovf[0]});
            chk("pc[1]",    pc1,    mon_e.pc[1]);
            chk("inst[1]",  inst1,  mon_e.inst[1]);
            chk("dout[1]",  dout1,  mon_e.dout[1]);
            chk("maddr[1]", maddr1, mon_e.maddr[1]);
            chk("zero[1]",  {31'h0, zero1}, {31'h0, mon_e.zero[1]});
            chk("ovf[1]",   {31'h0, ovf1},  {31'h0, mon_e.ovf[1]});
        end
    end

    initial begin
        ctl_t c;
        reset = 1'b0;
        MIO_ready = 1'b1; IorD = 1'b0; IRWrite = 1'b0; RegWrite = 1'b0; ALUSrcA = 1'b0;
        PCWrite = 1'b0; PCWriteCond = 1'b0; Branch = 1'b0; ExtSel = 1'b0;
        RegDst = 2'd0; MemtoReg = 2'd0; ALUSrcB = 2'd0; PCSource = 2'd0;
        ALU_operation = 3'd0; data2CPU = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset pc0", pc0, 32'h0);
        chk("reset pc1", pc1, 32'h100);
        chk("reset inst0", inst0, 32'h0);
        reset = 1'b1;

        // Fetch
        set_inputs(fetch(32'h2008_0005));
        #1;
        chk("fetch maddr before edge", maddr0, 32'h0);
        step();
        chk("fetch pc", pc0, 32'd4);
        chk("fetch inst", inst0, 32'h2008_0005);

        // Stalled fetch completes exactly once
        do_reset();
        c = fetch(32'h2008_0005);
        c.rdy = 1'b0;
        repeat (3) cyc(c);
        chk("stall pc", pc0, 32'h0);
        chk("stall inst", inst0, 32'h0);
        cyc(fetch(32'h2008_0005));
        chk("post-stall pc", pc0, 32'd4);
        chk("post-stall inst", inst0, 32'h2008_0005);
        cyc(idle());
        chk("fetch once pc", pc0, 32'd4);

        // bne with equal then unequal operands
        do_reset();
        load_imm_reg(32'h2008_0005);
        load_imm_reg(32'h2009_0005);
        cyc(fetch(32'h1509_0003));
        c = idle(); c.srcb = 2'd3; c.op = 3'b010;
        cyc(c);
        c = idle(); c.srca = 1'b1; c.op = 3'b110; c.pcwc = 1'b1; c.br = 1'b0; c.pcsrc = 2'd1;
        set_inputs(c);
        #1;
        chk("bne equal zero", {31'h0, zero0}, 32'd1);
        step();
        chk("bne not taken pc", pc0, 32'd12);
        load_imm_reg(32'h2009_0006);
        cyc(fetch(32'h1509_0003));
        c = idle(); c.srcb = 2'd3; c.op = 3'b010;
        cyc(c);
        c = idle(); c.srca = 1'b1; c.op = 3'b110; c.pcwc = 1'b1; c.br = 1'b0; c.pcsrc = 2'd1;
        cyc(c);
        chk("bne taken pc", pc0, 32'd32);

        // j to 0x40, link, then jr through the link register
        cyc(fetch(32'h0C00_0010));
        c = idle(); c.pcsrc = 2'd2; c.pcw = 1'b1;
        cyc(c);
        chk("jump pc", pc0, 32'h40);
        c = idle(); c.rw = 1'b1; c.rdst = 2'd2; c.m2r = 2'd3;
        cyc(c);
        cyc(fetch(32'h03E0_0008));
        chk("pc after fetch jr", pc0, 32'h44);
        cyc(idle());
        c = idle(); c.pcsrc = 2'd3; c.pcw = 1'b1;
        cyc(c);
        chk("jr pc0", pc0, 32'h40);
        chk("jr pc1", pc1, 32'h40);

        // SUB 5-5 and ADD overflow
        cyc(fetch(32'h2100_0005));
        cyc(idle());
        c = idle(); c.srca = 1'b1; c.srcb = 2'd2; c.op = 3'b110;
        set_inputs(c);
        #1;
        chk("sub zero", {31'h0, zero0}, 32'd1);
        chk("sub ovf", {31'h0, ovf0}, 32'd0);
        step();
        cyc(fetch(32'h3C0A_8000));
        cyc(idle());
        c = idle(); c.rw = 1'b1; c.m2r = 2'd2;
        cyc(c);
        load_imm_reg(32'h214A_FFFF);
        cyc(fetch(32'h2140_0001));
        cyc(idle());
        c = idle(); c.srca = 1'b1; c.srcb = 2'd2; c.op = 3'b010; c.pcw = 1'b1;
        set_inputs(c);
        #1;
        chk("add ovf", {31'h0, ovf0}, 32'd1);
        chk("add zero", {31'h0, zero0}, 32'd0);
        step();
        chk("add result via pc", pc0, 32'h8000_0000);

        // Address truncation on the 8-register instance, r0 write ignored
        cyc(fetch(32'h3C00_6800));
        cyc(idle());
        c = idle(); c.rw = 1'b1; c.rdst = 2'd1; c.m2r = 2'd2;
        cyc(c);
        cyc(fetch(32'h0005_0000));
        cyc(idle());
        chk("nreg8 r5 readback", dout1, 32'h6800_0000);
        chk("nreg32 r5 untouched", dout0, 32'h0);
        load_imm_reg(32'h2008_FFFF);
        cyc(idle());
        chk("nreg32 r8 written", dout0, 32'hFFFF_FFFF);
        chk("nreg8 r0 stays zero", dout1, 32'h0);

        // Randomised run with a reset in the middle
        for (int i = 0; i < 400; i++) begin
            cyc(rnd_ctl());
            if (i == 200) do_reset();
        end

        step();
        chk("scoreboard drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
